microwave_ctrl: RTL and testbench

//  Control FSM directly upstream of the countdown timer. Debounces the front-panel buttons and

---
 rtl/microwave_ctrl.sv | 160 ++++++++++++++++
 tb/tb_microwave_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/microwave_ctrl.sv
// Microwave control FSM: debounced panel inputs, keypad gating and
// timer, magnetron and beeper drive.
module microwave_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BEEP_CYCLES     = 3,
  parameter int MAX_DIGITS      = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       clear_btn,
  input  logic       door_closed,
  input  logic       key_valid,
  input  logic       timer_done,
  output logic       key_accept,
  output logic       loadn,
  output logic       clearn,
  output logic       enable,
  output logic       mag_on,
  output logic       beep,
  output logic [2:0] state
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DW = $clog2(MAX_DIGITS + 1);
  localparam int BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;

  logic [3:0]    raw;
  logic [3:0]    s1;
  logic [3:0]    s2;
  logic [3:0]    lvl;
  logic [2:0]    lvl_d;
  logic [2:0]    ev;
  logic [CW-1:0] cnt [4];

  assign raw = {door_closed, clear_btn, stop_btn, start_btn};

  // bit 3 is the door (level only); bits 2:0 are buttons (rising-edge events)
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1    <= '0;
      s2    <= '0;
      lvl   <= '0;
      lvl_d <= '0;
      ev    <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      lvl_d <= lvl[2:0];
      ev    <= lvl[2:0] & ~lvl_d;
      for (int i = 0; i < 4; i++) begin
        if (s2[i] == lvl[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          lvl[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  state_t        cur;
  state_t        nxt;
  logic [DW-1:0] digits;
  logic [BW-1:0] beep_cnt;
  logic          door_ok;
  logic          start_ev;
  logic          stop_ev;
  logic          clear_ev;
  logic          clr_exit;

  assign {clear_ev, stop_ev, start_ev} = ev;
  assign door_ok = lvl[3];
  assign state   = cur;

  assign key_accept = key_valid
                   && (cur == IDLE || cur == SETUP)
                   && (digits < DW'(MAX_DIGITS));

  always_comb begin
    nxt      = cur;
    clr_exit = 1'b0;
    unique case (cur)
      IDLE: begin
        if (clear_ev) clr_exit = 1'b1;
        else if (key_accept) nxt = SETUP;
      end
      SETUP: begin
        if (clear_ev) begin
          nxt      = IDLE;
          clr_exit = 1'b1;
        end else if (start_ev && door_ok) begin
          nxt = COOK;
        end
      end
      COOK: begin
        if (timer_done) nxt = DONE;
        else if (stop_ev || !door_ok) nxt = PAUSE;
      end
      PAUSE: begin
        if (clear_ev) begin
          nxt      = IDLE;
          clr_exit = 1'b1;
        end else if (start_ev && door_ok) begin
          nxt = COOK;
        end
      end
      DONE: begin
        if (clear_ev || stop_ev || !door_ok) begin
          nxt      = IDLE;
          clr_exit = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // outputs are registered from nxt so they line up with state
  always_ff @(posedge CLK) begin
    if (RST) begin
      cur      <= IDLE;
      digits   <= '0;
      beep_cnt <= '0;
      loadn    <= 1'b0;
      clearn   <= 1'b0;
      enable   <= 1'b0;
      mag_on   <= 1'b0;
      beep     <= 1'b0;
    end else begin
      cur <= nxt;
      if (nxt == IDLE && (cur != IDLE || clr_exit)) digits <= '0;
      else if (key_accept) digits <= digits + 1'b1;
      loadn  <= !(nxt == IDLE || nxt == SETUP);
      enable <= (nxt == COOK);
      mag_on <= (nxt == COOK);
      clearn <= !clr_exit;
      if (nxt == DONE && cur != DONE) begin
        beep     <= 1'b1;
        beep_cnt <= BW'(BEEP_CYCLES - 1);
      end else if (nxt == DONE && beep_cnt != '0) begin
        beep     <= 1'b1;
        beep_cnt <= beep_cnt - 1'b1;
      end else begin
        beep     <= 1'b0;
        beep_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_microwave_ctrl.sv
// Bench for microwave_ctrl: directed vector table, multi-cycle
// corner sequences and random stimulus against a reference model.
module tb_microwave_ctrl;
  logic       CLK = 1'b0;
  logic       RST;
  logic       start_btn, stop_btn, clear_btn, door_closed;
  logic       key_valid, timer_done;
  logic       key_accept, loadn, clearn, enable, mag_on, beep;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  microwave_ctrl dut (
    .CLK(CLK), .RST(RST),
    .start_btn(start_btn), .stop_btn(stop_btn),
    .clear_btn(clear_btn), .door_closed(door_closed),
    .key_valid(key_valid), .timer_done(timer_done),
    .key_accept(key_accept), .loadn(loadn), .clearn(clearn),
    .enable(enable), .mag_on(mag_on), .beep(beep), .state(state)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic rst, start, stop, clear, door, kv, td;
    int   hold;
    logic [2:0] st;
    logic ld, cl, en, bp, ka;
  } vec_t;

  function automatic vec_t mk(input int r, s, p, c, d, k, t, h,
                              input int st, ld, cl, en, bp, ka);
    vec_t v;
    v.rst = r[0]; v.start = s[0]; v.stop = p[0]; v.clear = c[0];
    v.door = d[0]; v.kv = k[0]; v.td = t[0]; v.hold = h;
    v.st = st[2:0]; v.ld = ld[0]; v.cl = cl[0];
    v.en = en[0]; v.bp = bp[0]; v.ka = ka[0];
    return v;
  endfunction

  // reference model: spec rules over sample histories
  int         m_st, m_dc, m_dcyc;
  logic       m_ld, m_cl, m_en, m_bp;
  logic [5:0] m_raw [4];
  logic [2:0] m_lv  [4];

  function automatic logic m_ka(input logic kv);
    return kv && (m_st <= 1) && (m_dc < 4);
  endfunction

  task automatic m_step(input logic r, input logic [3:0] b,
                        input logic kv, input logic td);
    logic evs, evp, evc, dok, ka, clr, nl;
    int   nst;
    if (r) begin
      m_st = 0; m_dc = 0; m_dcyc = 0;
      m_ld = 0; m_cl = 0; m_en = 0; m_bp = 0;
      for (int i = 0; i < 4; i++) begin
        m_raw[i] = '0;
        m_lv[i]  = '0;
      end
    end else begin
      evs = m_lv[0][1] & ~m_lv[0][2];
      evp = m_lv[1][1] & ~m_lv[1][2];
      evc = m_lv[2][1] & ~m_lv[2][2];
      dok = m_lv[3][0];
      ka  = m_ka(kv);
      nst = m_st;
      clr = 0;
      case (m_st)
        0: if (evc) clr = 1; else if (ka) nst = 1;
        1: if (evc) begin nst = 0; clr = 1; end
           else if (evs && dok) nst = 2;
        2: if (td) nst = 4; else if (evp || !dok) nst = 3;
        3: if (evc) begin nst = 0; clr = 1; end
           else if (evs && dok) nst = 2;
        default: if (evc || evp || !dok) begin nst = 0; clr = 1; end
      endcase
      if (nst == 0 && (m_st != 0 || clr)) m_dc = 0;
      else if (ka && m_dc < 4) m_dc++;
      m_dcyc = (nst == 4) ? ((m_st == 4) ? m_dcyc + 1 : 1) : 0;
      m_st = nst;
      m_ld = !(nst <= 1);
      m_en = (nst == 2);
      m_cl = !clr;
      m_bp = (nst == 4) && (m_dcyc <= 3);
      // level flips once the last 4 synchronized samples all disagree
      for (int i = 0; i < 4; i++) begin
        m_raw[i] = {m_raw[i][4:0], b[i]};
        nl = m_lv[i][0];
        if (m_raw[i][5:2] == {4{~nl}}) nl = ~nl;
        m_lv[i] = {m_lv[i][1:0], nl};
      end
    end
  endtask

  vec_t tbl [21];
  int   cook_at, exit_at, acc;
  logic cl_at_exit;
  int   hold_c [4];
  logic [3:0] rv;

  initial begin
    tbl[0]  = mk(1,0,0,0,1,0,0, 3, 0,0,0,0,0,0);
    tbl[1]  = mk(0,0,0,0,1,0,0, 1, 0,0,1,0,0,0);
    tbl[2]  = mk(0,0,0,0,1,1,0, 5, 1,0,1,0,0,0);
    tbl[3]  = mk(0,1,0,0,1,0,0, 8, 2,1,1,1,0,0);
    tbl[4]  = mk(0,1,0,1,1,0,0, 8, 2,1,1,1,0,0);
    tbl[5]  = mk(0,0,0,0,1,0,0, 6, 2,1,1,1,0,0);
    tbl[6]  = mk(0,0,0,0,0,0,0, 6, 2,1,1,1,0,0);
    tbl[7]  = mk(0,0,0,0,0,0,0, 1, 3,1,1,0,0,0);
    tbl[8]  = mk(0,0,0,0,1,0,0, 6, 3,1,1,0,0,0);
    tbl[9]  = mk(0,1,0,0,1,0,0, 8, 2,1,1,1,0,0);
    tbl[10] = mk(0,0,0,0,1,0,1, 1, 4,1,1,0,1,0);
    tbl[11] = mk(0,0,0,0,1,0,0, 2, 4,1,1,0,1,0);
    tbl[12] = mk(0,0,0,0,1,0,0, 1, 4,1,1,0,0,0);
    tbl[13] = mk(0,0,0,1,1,0,0, 8, 0,0,0,0,0,0);
    tbl[14] = mk(0,0,0,1,1,0,0, 1, 0,0,1,0,0,0);
    tbl[15] = mk(0,0,0,0,1,1,0, 1, 1,0,1,0,0,1);
    tbl[16] = mk(0,0,0,0,0,0,0, 7, 1,0,1,0,0,0);
    tbl[17] = mk(0,1,0,0,0,0,0,10, 1,0,1,0,0,0);
    tbl[18] = mk(0,0,0,0,1,0,0,12, 1,0,1,0,0,0);
    tbl[19] = mk(0,1,0,0,1,0,0, 8, 2,1,1,1,0,0);
    tbl[20] = mk(1,1,0,0,1,0,0, 1, 0,0,0,0,0,0);

    for (int i = 0; i < 21; i++) begin
      RST = tbl[i].rst; start_btn = tbl[i].start;
      stop_btn = tbl[i].stop; clear_btn = tbl[i].clear;
      door_closed = tbl[i].door; key_valid = tbl[i].kv;
      timer_done = tbl[i].td;
      repeat (tbl[i].hold) @(posedge CLK);
      #1;
      chk($sformatf("vec%0d", i),
          16'({state, loadn, clearn, enable, mag_on, beep, key_accept}),
          16'({tbl[i].st, tbl[i].ld, tbl[i].cl, tbl[i].en,
               tbl[i].en, tbl[i].bp, tbl[i].ka}));
    end

    RST = 1; start_btn = 0; stop_btn = 0; clear_btn = 0;
    door_closed = 1; key_valid = 0; timer_done = 0;
    repeat (2) @(posedge CLK);
    #1 RST = 0;
    repeat (8) @(posedge CLK);
    #1;
    for (int i = 0; i < 5; i++) begin
      key_valid = 1;
      #1 chk($sformatf("key_acc%0d", i), 16'(key_accept), 16'(i < 4));
      @(posedge CLK);
      #1 key_valid = 0;
      @(posedge CLK);
      #1;
    end
    chk("setup_state", 16'(state), 16'd1);

    for (int j = 0; j < 10; j++) begin
      start_btn = (j % 2 == 0);
      @(posedge CLK);
      #1;
    end
    chk("bounce_no_event", 16'(state), 16'd1);
    start_btn = 1;
    cook_at = 0;
    for (int k = 1; k <= 30 && cook_at == 0; k++) begin
      @(posedge CLK);
      #1;
      if (state == 3'd2) cook_at = k;
    end
    chk("bounce_latency", 16'(cook_at), 16'd8);
    chk("cook_outputs", 16'({loadn, enable, mag_on}), 16'b111);

    timer_done = 1;
    @(posedge CLK);
    #1 timer_done = 0;
    chk("done_entry", 16'({state, mag_on, beep}), 16'({3'd4, 1'b0, 1'b1}));
    for (int k = 2; k <= 5; k++) begin
      @(posedge CLK);
      #1 chk($sformatf("beep_c%0d", k), 16'(beep), 16'(k <= 3));
    end
    stop_btn = 1;
    exit_at = 0;
    cl_at_exit = 1;
    for (int k = 1; k <= 30 && exit_at == 0; k++) begin
      @(posedge CLK);
      #1;
      if (state == 3'd0) begin
        exit_at = k;
        cl_at_exit = clearn;
      end
    end
    chk("stop_exit_cycle", 16'(exit_at), 16'd8);
    chk("stop_exit_clearn", 16'(cl_at_exit), 16'd0);
    @(posedge CLK);
    #1 chk("clearn_one_cycle", 16'(clearn), 16'd1);
    stop_btn = 0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      key_valid = 1;
      #1 if (key_accept) acc++;
      @(posedge CLK);
      #1 key_valid = 0;
      @(posedge CLK);
      #1;
    end
    chk("digits_cleared", 16'(acc), 16'd4);

    RST = 1; start_btn = 0; stop_btn = 0; clear_btn = 0;
    door_closed = 0; key_valid = 0; timer_done = 0;
    @(posedge CLK);
    m_step(1, 4'b0, 0, 0);
    @(posedge CLK);
    m_step(1, 4'b0, 0, 0);
    #1 RST = 0;
    for (int i = 0; i < 4; i++) hold_c[i] = 0;
    rv = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (hold_c[i] == 0) begin
          rv[i] = (i == 3) ? ($urandom_range(0, 4) != 0)
                           : ($urandom_range(0, 2) == 0);
          hold_c[i] = $urandom_range(1, 12);
        end else begin
          hold_c[i]--;
        end
      end
      {door_closed, clear_btn, stop_btn, start_btn} = rv;
      RST = ($urandom_range(0, 299) == 0);
      key_valid = ($urandom_range(0, 3) == 0);
      timer_done = ($urandom_range(0, 11) == 0);
      #1 chk("rnd_ka", 16'(key_accept), 16'(m_ka(key_valid)));
      @(posedge CLK);
      m_step(RST, rv, key_valid, timer_done);
      #1 chk("rnd_out",
             16'({state, loadn, clearn, enable, mag_on, beep}),
             16'({3'(m_st), m_ld, m_cl, m_en, m_en, m_bp}));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
